elevator_call_panel: RTL and testbench

Hall-call front end for the two-floor `elevator_controller`. It synchronises and debounces the two raw call buttons and latches each press as a pending call with a lamp output. It then drives the controller's `req0`/`req1` inputs with single-cycle request pulses and watches `floor`/`moving` to detect arrival and clear the call. It sits between the push-button pads and the controller: the issuing end of the controller's request interface.

---
 rtl/elevator_call_panel.sv | 156 +++++++++++++++
 tb/tb_elevator_call_panel.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_panel.sv
`default_nettype none
// ============================================================================
// Module      : elevator_call_panel
// Description : Hall-call front end for a two-floor elevator controller.
//               Synchronises and debounces two call buttons, latches calls
//               as pending lamps, issues single-cycle requests to the
//               controller, retries on timeout and clears calls on arrival.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_call_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RETRY_CYCLES    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0,
    input  logic btn1,
    input  logic floor,
    input  logic moving,
    output logic req0,
    output logic req1,
    output logic pend0,
    output logic pend1,
    output logic busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(RETRY_CYCLES);
    localparam logic [CW-1:0] c_deb_last   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] c_retry_last = TW'(RETRY_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Input path registers, index 0/1 = floor 0/1 button
    logic [1:0]    w_btn;
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_stable;
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    w_rise;

    // Call and controller-side state
    logic [1:0]    r_pend;
    logic [1:0]    r_req;
    state_t        r_state;
    logic          r_tgt;
    logic [TW-1:0] r_timer;

    state_t        w_state_nxt;
    logic          w_tgt_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [1:0]    w_req_nxt;
    logic [1:0]    w_clr;

    assign w_btn = {btn1, btn0};

    // Two-flop synchroniser followed by a hold-time debouncer per button
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            r_s1 <= w_btn;
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] != r_stable[i]) begin
                    if (r_cnt[i] == c_deb_last) begin
                        r_stable[i] <= r_s2[i];
                        r_cnt[i]    <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Debounced rising edge: asserted on the cycle the stable level flips to 1
    always_comb begin
        w_rise = '0;
        for (int i = 0; i < 2; i++) begin
            w_rise[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == c_deb_last) && r_s2[i];
        end
    end

    // State, target, retry timer, request pulses and call latches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tgt   <= 1'b0;
            r_timer <= '0;
            r_req   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_timer <= w_timer_nxt;
            r_req   <= w_req_nxt;
            // A clear on the same edge as a new press wins: the car is there
            r_pend  <= (r_pend | w_rise) & ~w_clr;
        end
    end

    // Next-state logic: serve current floor locally, otherwise request and wait
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_timer_nxt = r_timer;
        w_req_nxt   = '0;
        w_clr       = '0;
        case (r_state)
            S_IDLE: begin
                if (!moving && r_pend[floor]) begin
                    w_clr[floor] = 1'b1;
                end else if (!moving && r_pend[~floor]) begin
                    w_tgt_nxt   = ~floor;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_req_nxt[r_tgt] = 1'b1;
                w_timer_nxt      = '0;
                w_state_nxt      = S_WAIT;
            end
            S_WAIT: begin
                if ((floor == r_tgt) && !moving) begin
                    w_clr[r_tgt] = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (r_timer == c_retry_last) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req0  = r_req[0];
    assign req1  = r_req[1];
    assign pend0 = r_pend[0];
    assign pend1 = r_pend[1];
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_panel.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_call_panel
// Description : Self-checking bench for elevator_call_panel (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_call_panel;

    logic clk = 1'b0;
    logic rst, btn0, btn1, floor, moving;
    logic req0, req1, pend0, pend1, busy;

    int n_pass  = 0;
    int n_total = 0;

    elevator_call_panel #(.DEBOUNCE_CYCLES(4), .RETRY_CYCLES(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .btn0   (btn0),
        .btn1   (btn1),
        .floor  (floor),
        .moving (moving),
        .req0   (req0),
        .req1   (req1),
        .pend0  (pend0),
        .pend1  (pend1),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Output vector order: {req0, req1, pend0, pend1, busy}
    typedef struct {
        logic       r;
        logic       b0;
        logic       b1;
        logic       fl;
        logic       mv;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [4:0] outs();
        return {req0, req1, pend0, pend1, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic add(input logic r, input logic b0, input logic b1,
                       input logic fl, input logic mv, input logic [4:0] exp);
        vec_t v;
        v.r = r; v.b0 = b0; v.b1 = b1; v.fl = fl; v.mv = mv; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t_req[3];
        int   n_req;
        logic seen;

        rst = 1'b1; btn0 = 1'b0; btn1 = 1'b0; floor = 1'b0; moving = 1'b0;

        // Reset with toggling buttons, then floor-1 call served by arrival
        add(1, 1, 0, 0, 0, 5'b00000);
        add(1, 0, 1, 0, 0, 5'b00000);
        add(1, 1, 1, 0, 0, 5'b00000);
        add(0, 0, 0, 0, 0, 5'b00000);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 5'b00000);
        add(0, 0, 1, 0, 0, 5'b00010);   // edge 6: pend1 latches
        add(0, 0, 1, 0, 0, 5'b00011);   // IDLE decides to issue
        add(0, 0, 1, 0, 0, 5'b01011);   // req1 pulse
        add(0, 0, 1, 0, 0, 5'b00011);
        add(0, 0, 1, 0, 1, 5'b00011);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 5'b00011);
        add(0, 0, 0, 1, 0, 5'b00000);   // arrival clears call
        add(0, 0, 0, 1, 0, 5'b00000);

        foreach (tbl[i]) begin
            rst = tbl[i].r; btn0 = tbl[i].b0; btn1 = tbl[i].b1;
            floor = tbl[i].fl; moving = tbl[i].mv;
            step();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Let btn1 release settle
        for (int i = 0; i < 8; i++) step();

        // Glitch rejection: 2-cycle pulse on btn0 with car at floor 1
        floor = 1'b1;
        btn0  = 1'b1;
        step(); step();
        btn0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (pend0 || req0 || busy) seen = 1'b1;
        end
        chk("glitch_filtered", {4'b0, seen}, 5'b0);

        // Current-floor call: pend0 for one cycle, no request, never busy
        floor = 1'b0;
        btn0  = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("curfloor_pre", outs(), 5'b00000);
        step();
        chk("curfloor_pend", outs(), 5'b00100);
        step();
        chk("curfloor_clr", outs(), 5'b00000);
        btn0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (outs() != 5'b00000) seen = 1'b1;
        end
        chk("curfloor_quiet", {4'b0, seen}, 5'b0);

        // Retry: unresponsive controller, req1 every RETRY_CYCLES+1 cycles
        btn1  = 1'b1;
        n_req = 0;
        seen  = 1'b0;
        for (int i = 0; i < 3; i++) t_req[i] = -1;
        for (int t = 1; t <= 60 && n_req < 3; t++) begin
            if (t == 11) btn1 = 1'b0;
            step();
            if (req0) seen = 1'b1;
            if (req1) begin
                t_req[n_req] = t;
                n_req++;
            end
        end
        chk("retry_first",  5'(t_req[0]), 5'(8));
        chk("retry_gap1",   5'(t_req[1] - t_req[0]), 5'(17));
        chk("retry_gap2",   5'(t_req[2] - t_req[1]), 5'(17));
        chk("retry_no_req0", {4'b0, seen}, 5'b0);
        chk("retry_state",  outs(), 5'b01011);

        // Arrival at floor 1 mid-WAIT while btn0 is pressed
        floor = 1'b1;
        btn0  = 1'b1;
        step();
        chk("arrive_clr", outs(), 5'b00000);
        for (int i = 0; i < 4; i++) step();
        chk("b0_pre", outs(), 5'b00000);
        step();
        chk("b0_pend", outs(), 5'b00100);
        step();
        chk("b0_issue", outs(), 5'b00101);
        step();
        chk("b0_req", outs(), 5'b10101);
        btn0 = 1'b0;
        step();
        chk("b0_wait", outs(), 5'b00101);

        // Reset for one cycle mid-WAIT drops the call; no request follows
        rst = 1'b1;
        step();
        chk("rst_mid", outs(), 5'b00000);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (outs() != 5'b00000) seen = 1'b1;
        end
        chk("rst_quiet", {4'b0, seen}, 5'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
